// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter for init, refresh, write and read.
// Define SDRAM_ARB_STAT_EN to add refresh count / worst refresh wait outputs.
module sdram_arbit #(
    parameter int          ADDR_W  = 13,
    parameter logic [3:0]  CMD_NOP = 4'b0111,
    parameter int          STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    output logic              aref_en,
    input  logic              flag_aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    output logic              wr_en,
    input  logic              flag_wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_req,
    output logic              rd_en,
    input  logic              flag_rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_pending,
    output logic              aref_overrun,
`ifdef SDRAM_ARB_STAT_EN
    output logic [STAT_W-1:0] aref_cnt,
    output logic [STAT_W-1:0] aref_wait_max,
`endif
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_AREF, S_WRITE, S_READ
    } state_t;

    state_t state_q, state_d;
    logic   pend_q, pend_d;
    logic   ovr_q, ovr_d;
    logic   grant_aref;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        ovr_d      = ovr_q;
        grant_aref = 1'b0;
        unique case (state_q)
            S_INIT:  if (flag_init_end) state_d = S_IDLE;
            S_IDLE: begin
                if (aref_req || pend_q) begin
                    state_d    = S_AREF;
                    grant_aref = 1'b1;
                end else if (wr_req) begin
                    state_d = S_WRITE;
                end else if (rd_req) begin
                    state_d = S_READ;
                end
            end
            S_AREF:  if (flag_aref_end) state_d = S_IDLE;
            S_WRITE: if (flag_wr_end) state_d = S_IDLE;
            S_READ:  if (flag_rd_end) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
        // A request arriving while one is already outstanding is merged away.
        if (aref_req && (pend_q || state_q == S_AREF)) ovr_d = 1'b1;
        if (grant_aref) pend_d = 1'b0;
        else if (aref_req) pend_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    assign aref_en      = (state_q == S_AREF);
    assign wr_en        = (state_q == S_WRITE);
    assign rd_en        = (state_q == S_READ);
    assign aref_pending = pend_q;
    assign aref_overrun = ovr_q;

    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        unique case (state_q)
            S_INIT:  begin sdram_cmd = init_cmd; sdram_addr = init_addr; end
            S_AREF:  begin sdram_cmd = aref_cmd; sdram_addr = aref_addr; end
            S_WRITE: begin sdram_cmd = wr_cmd;   sdram_addr = wr_addr;   end
            S_READ:  begin sdram_cmd = rd_cmd;   sdram_addr = rd_addr;   end
            default: ;
        endcase
    end

`ifdef SDRAM_ARB_STAT_EN
    localparam logic [STAT_W-1:0] SAT = '1;

    logic [STAT_W-1:0] cnt_q, cnt_d;
    logic [STAT_W-1:0] wait_q, wait_d;
    logic [STAT_W-1:0] max_q, max_d;
    logic [STAT_W-1:0] wait_cur;

    // wait_cur counts the current cycle too, so it equals the pending span.
    always_comb begin
        wait_cur = '0;
        if (pend_q) wait_cur = (wait_q == SAT) ? SAT : wait_q + 1'b1;
        wait_d = pend_q ? wait_cur : '0;
        cnt_d  = cnt_q;
        max_d  = max_q;
        if (grant_aref) begin
            cnt_d = cnt_q + 1'b1;
            if (wait_cur > max_q) max_d = wait_cur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wait_q <= '0;
            max_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wait_q <= wait_d;
            max_q  <= max_d;
        end
    end

    assign aref_cnt      = cnt_q;
    assign aref_wait_max = max_q;
`endif

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: directed scenarios plus randomized traffic
// compared each cycle against an owner-based reference model.
module tb_sdram_arbit;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flag_init_end = 1'b0;
    logic [3:0]    init_cmd = 4'b0010;
    logic [AW-1:0] init_addr = '0;
    logic          aref_req = 1'b0;
    logic          aref_en;
    logic          flag_aref_end = 1'b0;
    logic [3:0]    aref_cmd = 4'b0001;
    logic [AW-1:0] aref_addr = 13'h0400;
    logic          wr_req = 1'b0;
    logic          wr_en;
    logic          flag_wr_end = 1'b0;
    logic [3:0]    wr_cmd = 4'b0100;
    logic [AW-1:0] wr_addr = 13'h0123;
    logic          rd_req = 1'b0;
    logic          rd_en;
    logic          flag_rd_end = 1'b0;
    logic [3:0]    rd_cmd = 4'b0101;
    logic [AW-1:0] rd_addr = 13'h0456;
    logic          aref_pending;
    logic          aref_overrun;
    logic [3:0]    sdram_cmd;
    logic [AW-1:0] sdram_addr;
`ifdef SDRAM_ARB_STAT_EN
    logic [15:0]   aref_cnt;
    logic [15:0]   aref_wait_max;
`endif

    sdram_arbit dut (
        .clk(clk), .rst(rst),
        .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_en(aref_en),
        .flag_aref_end(flag_aref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_en(wr_en),
        .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_en(rd_en),
        .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr),
        .aref_pending(aref_pending),
        .aref_overrun(aref_overrun),
`ifdef SDRAM_ARB_STAT_EN
        .aref_cnt(aref_cnt),
        .aref_wait_max(aref_wait_max),
`endif
        .sdram_cmd(sdram_cmd),
        .sdram_addr(sdram_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 init, 0 nobody, 1 aref, 2 wr, 3 rd).
    int          m_own = -1;
    bit          m_pend = 0;
    bit          m_ovr = 0;
    logic [15:0] m_cnt = '0;
    int          m_max = 0;
    int          cyc = 0;
    int          pstart = 0;
    int          nxt;
    int          dly;
    bit          take;
    bit          ended;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_own  = -1;
            m_pend = 0;
            m_ovr  = 0;
            m_cnt  = '0;
            m_max  = 0;
        end else begin
            cyc++;
            take  = (m_own == 0) && (aref_req || m_pend);
            ended = (m_own == 1 && flag_aref_end) ||
                    (m_own == 2 && flag_wr_end) ||
                    (m_own == 3 && flag_rd_end);
            if (m_own == -1) nxt = flag_init_end ? 0 : -1;
            else if (m_own == 0)
                nxt = take ? 1 : wr_req ? 2 : rd_req ? 3 : 0;
            else nxt = ended ? 0 : m_own;
            if (aref_req && (m_pend || m_own == 1)) m_ovr = 1;
            if (take) begin
                m_cnt = m_cnt + 16'd1;
                dly = m_pend ? cyc - pstart : 0;
                if (dly > 65535) dly = 65535;
                if (dly > m_max) m_max = dly;
                m_pend = 0;
            end else if (aref_req && !m_pend) begin
                m_pend = 1;
                pstart = cyc;
            end
            m_own = nxt;
        end
    end

    int ecmd;
    int eaddr;
    always @(negedge clk) begin
        case (m_own)
            -1: begin ecmd = init_cmd; eaddr = init_addr; end
            1:  begin ecmd = aref_cmd; eaddr = aref_addr; end
            2:  begin ecmd = wr_cmd;   eaddr = wr_addr;   end
            3:  begin ecmd = rd_cmd;   eaddr = rd_addr;   end
            default: begin ecmd = 7; eaddr = 0; end
        endcase
        chk("m_aref_en", aref_en, m_own == 1);
        chk("m_wr_en", wr_en, m_own == 2);
        chk("m_rd_en", rd_en, m_own == 3);
        chk("m_pending", aref_pending, m_pend);
        chk("m_overrun", aref_overrun, m_ovr);
        chk("m_cmd", sdram_cmd, ecmd);
        chk("m_addr", sdram_addr, eaddr);
`ifdef SDRAM_ARB_STAT_EN
        chk("m_cnt", aref_cnt, m_cnt);
        chk("m_wmax", aref_wait_max, m_max);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        // Init hold, exit the cycle after flag_init_end.
        for (int i = 0; i < 20; i++) begin
            chk("init_cmd", sdram_cmd, 4'b0010);
            tick();
        end
        flag_init_end = 1'b1;
        chk("init_last", sdram_cmd, 4'b0010);
        tick();
        chk("idle_cmd", sdram_cmd, 4'b0111);
        chk("idle_addr", sdram_addr, 0);
        // Refresh beats a simultaneous write request.
        aref_req = 1'b1;
        wr_req   = 1'b1;
        tick();
        aref_req = 1'b0;
        chk("t2_aref_en", aref_en, 1);
        chk("t2_wr_en", wr_en, 0);
        chk("t2_pend", aref_pending, 0);
        chk("t2_cmd", sdram_cmd, 4'b0001);
        repeat (2) tick();
        flag_aref_end = 1'b1;
        tick();
        flag_aref_end = 1'b0;
        chk("t2_gap_aref", aref_en, 0);
        chk("t2_gap_wr", wr_en, 0);
        tick();
        chk("t2_wr_en", wr_en, 1);
        chk("t2_wr_cmd", sdram_cmd, 4'b0100);
        chk("t2_wr_addr", sdram_addr, 13'h0123);
        wr_req = 1'b0;
        // Refresh arriving mid-write waits 7 cycles.
        tick();
        aref_req = 1'b1;
        tick();
        aref_req = 1'b0;
        chk("t3_pend", aref_pending, 1);
        chk("t3_wr_on", wr_en, 1);
        repeat (5) tick();
        flag_wr_end = 1'b1;
        tick();
        flag_wr_end = 1'b0;
        chk("t3_gap_wr", wr_en, 0);
        chk("t3_gap_aref", aref_en, 0);
        chk("t3_gap_pend", aref_pending, 1);
        tick();
        chk("t3_aref_en", aref_en, 1);
        chk("t3_pend_clr", aref_pending, 0);
        flag_aref_end = 1'b1;
        tick();
        flag_aref_end = 1'b0;
        aref_req = 1'b1;
        tick();
        aref_req = 1'b0;
        chk("t6_aref_en", aref_en, 1);
        flag_aref_end = 1'b1;
        tick();
        flag_aref_end = 1'b0;
`ifdef SDRAM_ARB_STAT_EN
        chk("t6_cnt", aref_cnt, 3);
        chk("t6_wmax", aref_wait_max, 7);
`endif
        // Second request while pending -> sticky overrun.
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("t4_rd_en", rd_en, 1);
        aref_req = 1'b1;
        tick();
        chk("t4_pend", aref_pending, 1);
        chk("t4_no_ovr", aref_overrun, 0);
        tick();
        aref_req = 1'b0;
        chk("t4_ovr", aref_overrun, 1);
        flag_rd_end = 1'b1;
        tick();
        flag_rd_end = 1'b0;
        tick();
        chk("t4_aref_en", aref_en, 1);
        chk("t4_ovr_hold", aref_overrun, 1);
        flag_aref_end = 1'b1;
        tick();
        flag_aref_end = 1'b0;
        chk("t4_ovr_idle", aref_overrun, 1);
        // Asynchronous reset in the middle of a refresh.
        aref_req = 1'b1;
        tick();
        tick();
        aref_req = 1'b0;
        chk("t5_aref_en", aref_en, 1);
        chk("t5_pend", aref_pending, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_en", aref_en, 0);
        chk("t5_rst_cmd", sdram_cmd, 4'b0010);
        chk("t5_rst_pend", aref_pending, 0);
        chk("t5_rst_ovr", aref_overrun, 0);
        tick();
        rst = 1'b0;
        // Randomized traffic phases.
        for (int p = 0; p < 5; p++) begin
            int idly;
            rst = 1'b1;
            flag_init_end = 1'b0;
            tick();
            rst = 1'b0;
            idly = $urandom_range(2, 12);
            for (int c = 0; c < 500; c++) begin
                if (c >= idly) flag_init_end = 1'b1;
                aref_req      = ($urandom % 30) == 0;
                flag_aref_end = ($urandom % 4) == 0;
                flag_wr_end   = ($urandom % 5) == 0;
                flag_rd_end   = ($urandom % 5) == 0;
                if (m_own == 2) wr_req = 1'b0;
                else if (!wr_req) wr_req = ($urandom % 8) == 0;
                if (m_own == 3) rd_req = 1'b0;
                else if (!rd_req) rd_req = ($urandom % 8) == 0;
                init_cmd  = 4'($urandom);
                aref_cmd  = 4'($urandom);
                wr_cmd    = 4'($urandom);
                rd_cmd    = 4'($urandom);
                init_addr = AW'($urandom);
                aref_addr = AW'($urandom);
                wr_addr   = AW'($urandom);
                rd_addr   = AW'($urandom);
                tick();
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
